// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: microword, condition and memory handshake bundle.
// master drives the microword/conditions; slave is the sequencer.
interface micro_sequencer_if #(
  parameter int ADDR_W   = 7,
  parameter int FAMILY_W = 4,
  parameter int NCOND    = 8
);
  localparam int CSEL_W = (NCOND > 1) ? $clog2(NCOND) : 1;
  localparam int CPOS_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;

  logic [FAMILY_W-1:0] family_number;
  logic                cond_pass;
  logic [NCOND-1:0]    cond_in;
  logic                mem_ready;
  logic [ADDR_W-1:0]   uw_j;
  logic [1:0]          uw_type;
  logic [CSEL_W-1:0]   uw_csel;
  logic                uw_cen;
  logic [CPOS_W-1:0]   uw_cpos;
  logic                uw_mem;
  logic [ADDR_W-1:0]   uaddr;
  logic [ADDR_W-1:0]   next_uaddr;
  logic                stall;
  logic                stack_ovf;
  logic                stack_unf;

  modport master (
    output family_number, cond_pass, cond_in, mem_ready,
    output uw_j, uw_type, uw_csel, uw_cen, uw_cpos, uw_mem,
    input  uaddr, next_uaddr, stall, stack_ovf, stack_unf
  );

  modport slave (
    input  family_number, cond_pass, cond_in, mem_ready,
    input  uw_j, uw_type, uw_csel, uw_cen, uw_cpos, uw_mem,
    output uaddr, next_uaddr, stall, stack_ovf, stack_unf
  );
endinterface

// File: rtl/micro_sequencer.sv
// micro_sequencer: next-micro-address engine for the multicycle ARMv4 core.
// Ports: clk, rst (sync, active high), bus (micro_sequencer_if.slave).
// bus in : family_number, cond_pass, cond_in, mem_ready, uw_* microword.
// bus out: uaddr, next_uaddr, stall, stack_ovf, stack_unf.
// USEQ_RETURN_STACK_EN enables the CALL/RET return stack and its flags.
module micro_sequencer #(
  parameter int ADDR_W       = 7,
  parameter int FAMILY_W     = 4,
  parameter int NCOND        = 8,
  parameter int DECODE_SHIFT = 3,
  parameter int FETCH_ADDR   = 104,
  parameter int STACK_DEPTH  = 2
) (
  input logic clk,
  input logic rst,
  micro_sequencer_if.slave bus
);
  localparam logic [ADDR_W-1:0] FETCH = ADDR_W'(FETCH_ADDR);
  localparam int FW = FAMILY_W + DECODE_SHIFT;
  localparam logic [1:0] T_DEC  = 2'b01;
  localparam logic [1:0] T_CALL = 2'b10;
  localparam logic [1:0] T_RET  = 2'b11;

  logic [NCOND-1:0]  cond;
  logic              cbit;
  logic [ADDR_W-1:0] jt;
  logic [FW-1:0]     fam_sh;
  logic [ADDR_W-1:0] dec_t;
  logic [ADDR_W-1:0] nxt;
  logic [ADDR_W-1:0] uaddr_q;
  logic              stall;

  assign cond   = bus.cond_in;
  assign cbit   = bus.uw_cen & cond[bus.uw_csel];
  // selected condition is OR'd into one bit of the jump field
  assign jt     = bus.uw_j | (ADDR_W'(cbit) << bus.uw_cpos);
  assign fam_sh = FW'(bus.family_number) << DECODE_SHIFT;
  assign dec_t  = ADDR_W'(fam_sh);
  assign stall  = bus.uw_mem & ~bus.mem_ready;

  assign bus.uaddr      = uaddr_q;
  assign bus.next_uaddr = nxt;
  assign bus.stall      = stall;

`ifdef USEQ_RETURN_STACK_EN
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int IX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stk [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic              sp_full;
  logic              sp_empty;
  logic [ADDR_W-1:0] top;
  logic [ADDR_W-1:0] ret_addr;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              unf_set;
  logic              ovf_q;
  logic              unf_q;

  assign sp_full  = (sp == SP_W'(STACK_DEPTH));
  assign sp_empty = (sp == '0);
  assign top      = stk[IX_W'(sp - SP_W'(1))];
  assign ret_addr = uaddr_q + ADDR_W'(1);

  always_comb begin
    nxt     = jt;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (1'b1)
      (bus.uw_type == T_DEC):
        nxt = bus.cond_pass ? dec_t : FETCH;
      (bus.uw_type == T_CALL): begin
        // full stack drops the push but the jump is still taken
        if (sp_full) ovf_set = 1'b1;
        else         push    = 1'b1;
      end
      (bus.uw_type == T_RET): begin
        if (sp_empty) begin
          unf_set = 1'b1;
          nxt     = FETCH;
        end else begin
          pop = 1'b1;
          nxt = top;
        end
      end
      default: nxt = jt;
    endcase
    // memory wait freezes address, stack and flags
    if (stall) begin
      nxt     = uaddr_q;
      push    = 1'b0;
      pop     = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uaddr_q <= FETCH;
      sp      <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      uaddr_q <= nxt;
      if (push)     sp <= sp + SP_W'(1);
      else if (pop) sp <= sp - SP_W'(1);
      ovf_q <= ovf_q | ovf_set;
      unf_q <= unf_q | unf_set;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) stk[IX_W'(sp)] <= ret_addr;
  end

  assign bus.stack_ovf = ovf_q;
  assign bus.stack_unf = unf_q;
`else
  always_comb begin
    nxt = jt;
    unique case (1'b1)
      (bus.uw_type == T_DEC):
        nxt = bus.cond_pass ? dec_t : FETCH;
      (bus.uw_type == T_RET):
        nxt = FETCH;
      default: nxt = jt;
    endcase
    if (stall) nxt = uaddr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) uaddr_q <= FETCH;
    else     uaddr_q <= nxt;
  end

  assign bus.stack_ovf = 1'b0;
  assign bus.stack_unf = 1'b0;
`endif
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed vectors, queue-based reference model,
// per-cycle compare plus literal expectations.
module tb_micro_sequencer;
  localparam int DEPTH = 2;
`ifdef USEQ_RETURN_STACK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  micro_sequencer_if bus ();
  micro_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  int m_uaddr;
  int m_stk[$];
  bit m_ovf;
  bit m_unf;
  bit started = 1'b0;

  function automatic bit m_stall();
    return bus.uw_mem && !bus.mem_ready;
  endfunction

  function automatic int m_jt();
    int c;
    c = (bus.uw_cen && bus.cond_in[bus.uw_csel]) ? (1 << bus.uw_cpos) : 0;
    return (int'(bus.uw_j) | c) % 128;
  endfunction

  function automatic int m_next();
    if (m_stall()) return m_uaddr;
    case (bus.uw_type)
      2'd1: return bus.cond_pass ? (int'(bus.family_number) * 8) % 128 : 104;
      2'd3: begin
        if (!STK_EN || m_stk.size() == 0) return 104;
        return m_stk[$];
      end
      default: return m_jt();
    endcase
  endfunction

  always @(posedge clk) begin : model
    int n;
    if (rst) begin
      m_uaddr = 104;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      started = 1'b1;
    end else if (started) begin
      n = m_next();
      if (!m_stall() && STK_EN) begin
        if (bus.uw_type == 2'd2) begin
          if (m_stk.size() == DEPTH) m_ovf = 1'b1;
          else m_stk.push_back((m_uaddr + 1) % 128);
        end else if (bus.uw_type == 2'd3) begin
          if (m_stk.size() == 0) m_unf = 1'b1;
          else void'(m_stk.pop_back());
        end
      end
      m_uaddr = n;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_uaddr", bus.uaddr, m_uaddr);
      chk("m_next", bus.next_uaddr, m_next());
      chk("m_stall", bus.stall, m_stall());
      chk("m_ovf", bus.stack_ovf, m_ovf);
      chk("m_unf", bus.stack_unf, m_unf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic uw(input int t, input int j, input int cen,
                    input int csel, input int cpos, input int mem);
    bus.uw_type = t[1:0];
    bus.uw_j    = j[6:0];
    bus.uw_cen  = cen[0];
    bus.uw_csel = csel[2:0];
    bus.uw_cpos = cpos[2:0];
    bus.uw_mem  = mem[0];
  endtask

  initial begin
    bus.family_number = '0;
    bus.cond_pass = 1'b0;
    bus.cond_in = '0;
    bus.mem_ready = 1'b1;
    uw(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    chk("rst_uaddr", bus.uaddr, 104);
    chk("rst_ovf", bus.stack_ovf, 0);
    chk("rst_unf", bus.stack_unf, 0);
    rst = 1'b0;

    uw(0, 105, 0, 0, 0, 0);
    tick(); chk("seq", bus.uaddr, 105);

    uw(1, 0, 0, 0, 0, 0);
    bus.family_number = 4'd5; bus.cond_pass = 1'b1;
    tick(); chk("dec5", bus.uaddr, 40);
    bus.family_number = 4'd14;
    tick(); chk("dec14", bus.uaddr, 112);
    bus.cond_pass = 1'b0;
    tick(); chk("dec_nopass", bus.uaddr, 104);

    bus.cond_in = 8'b0000_0100;
    uw(0, 57, 1, 2, 1, 0);
    tick(); chk("cbr_set", bus.uaddr, 59);
    bus.cond_in = 8'b0000_0000;
    tick(); chk("cbr_clr", bus.uaddr, 57);
    bus.cond_in = 8'b0000_0100;
    uw(0, 26, 1, 2, 0, 0);
    tick(); chk("cbr_pos0", bus.uaddr, 27);
    bus.cond_in = 8'b0000_0001;
    uw(0, 0, 1, 0, 7, 0);
    tick(); chk("cbr_pos7", bus.uaddr, 0);

    uw(0, 44, 0, 0, 0, 0);
    tick(); chk("to44", bus.uaddr, 44);
    uw(0, 70, 0, 0, 0, 1);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", bus.uaddr, 44);
      chk("stall_on", bus.stall, 1);
    end
    bus.mem_ready = 1'b1;
    #1; chk("stall_off", bus.stall, 0);
    tick(); chk("stall_adv", bus.uaddr, 70);

    uw(0, 20, 0, 0, 0, 0);
    tick(); chk("to20", bus.uaddr, 20);
    uw(2, 80, 0, 0, 0, 0);
    tick(); chk("call1", bus.uaddr, 80);
    uw(2, 90, 0, 0, 0, 0);
    tick(); chk("call2", bus.uaddr, 90);
    uw(2, 100, 0, 0, 0, 0);
    tick(); chk("call3", bus.uaddr, 100);
    chk("ovf", bus.stack_ovf, STK_EN ? 1 : 0);
    uw(3, 0, 0, 0, 0, 0);
    tick(); chk("ret1", bus.uaddr, STK_EN ? 81 : 104);
    tick(); chk("ret2", bus.uaddr, STK_EN ? 21 : 104);
    tick(); chk("ret3", bus.uaddr, 104);
    chk("unf", bus.stack_unf, STK_EN ? 1 : 0);
    chk("ovf_sticky", bus.stack_ovf, STK_EN ? 1 : 0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_ovf", bus.stack_ovf, 0);
    chk("rst2_unf", bus.stack_unf, 0);
    uw(2, 30, 0, 0, 0, 0);
    tick(); chk("call_sp1", bus.uaddr, 30);
    uw(0, 50, 0, 0, 0, 1);
    bus.mem_ready = 1'b0;
    tick(); chk("mid_stall", bus.uaddr, 30);
    rst = 1'b1;
    tick();
    chk("mid_rst_uaddr", bus.uaddr, 104);
    chk("mid_rst_unf", bus.stack_unf, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_hold", bus.uaddr, 104);
    chk("post_rst_stall", bus.stall, 1);
    uw(3, 0, 0, 0, 0, 1);
    bus.mem_ready = 1'b1;
    tick();
    chk("post_rst_ret", bus.uaddr, 104);
    chk("post_rst_unf", bus.stack_unf, STK_EN ? 1 : 0);

    uw(0, 3, 0, 0, 0, 0);
    tick(); chk("final_seq", bus.uaddr, 3);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Parametrised microcode sequencer for the multicycle ARMv4 core. It is the next generation of the fixed-encoding `StateMachine`. It holds the current micro-address, which indexes an external asynchronous control-store ROM. Each cycle it computes the next address from the returned microword, the instruction family, and the condition inputs. Compared with the fixed version, it adds generalised condition-bit branching, memory-ready stalls, and an optional micro-subroutine return stack.

## Interface
Parameters:
- ADDR_W, 7, micro-address width
- FAMILY_W, 4, instruction family number width
- NCOND, 8, number of branch condition inputs
- DECODE_SHIFT, 3, decode target = family_number << DECODE_SHIFT
- FETCH_ADDR, 104, first fetch micro-address (reset/abort target)
- STACK_DEPTH, 2, return stack entries (≥1)

Ports:
- clk  in  1  clock; one clock domain, all state on rising edge
- rst  in  1  synchronous, active-high reset
- family_number  in  FAMILY_W  decoded instruction family
- cond_pass  in  1  ARM condition-code check result for current instruction
- cond_in  in  NCOND  branch condition vector (ST, PL, A, IR_20, …)
- mem_ready  in  1  memory handshake; 1 = access completes this cycle
- uw_j  in  ADDR_W  microword next-address field
- uw_type  in  2  00 SEQ, 01 DECODE, 10 CALL, 11 RET
- uw_csel  in  clog2(NCOND)  condition select
- uw_cen  in  1  condition branch enable
- uw_cpos  in  clog2(ADDR_W)  bit position the selected condition is OR'd into
- uw_mem  in  1  microword performs a memory access
- uaddr  out  ADDR_W  current micro-address (registered)
- next_uaddr  out  ADDR_W  combinational next address
- stall  out  1  holding for memory
- stack_ovf  out  1  sticky overflow flag
- stack_unf  out  1  sticky underflow flag

## Operation
Target computation (combinational):
- cbit = uw_cen & cond_in[uw_csel].
- jt = uw_j | (cbit << uw_cpos), truncated to ADDR_W.

Type selection:
- SEQ: next = jt.
- DECODE: next = cond_pass ? (family_number << DECODE_SHIFT) truncated to ADDR_W : FETCH_ADDR.
- CALL: push uaddr+1 (mod 2^ADDR_W); next = jt.
- RET: pop; next = popped value.

Stall:
- If uw_mem & !mem_ready, next = uaddr and stall = 1.
- During a stall, no push or pop occurs and the flags do not change.

Stack behaviour:
- Stack pointer sp runs 0..STACK_DEPTH.
- CALL with sp == STACK_DEPTH: stack_ovf set; the push is dropped; the jump is still taken.
- RET with sp == 0: stack_unf set; next = FETCH_ADDR.
- stack_ovf and stack_unf clear only on rst.

Reset:
- uaddr = FETCH_ADDR, sp = 0, stack_ovf = 0, stack_unf = 0.
- rst has priority over everything, including a stall in progress or a pending push/pop.

## Timing
- uaddr updates on every rising edge with next_uaddr.
- The microword must be valid within the same cycle as uaddr (asynchronous ROM).
- Zero-latency decision: next_uaddr and stall are combinational from the current microword and inputs.
- uaddr is valid on the first edge after rst deasserts. It equals FETCH_ADDR during the cycle in which rst is sampled high and on the following cycle.
- A stall lasts exactly as many cycles as mem_ready is low. The advance occurs on the edge where mem_ready = 1.
- A push or pop commits on the same edge as the uaddr update.

## Configuration
- USEQ_RETURN_STACK_EN defined: the stack, CALL/RET semantics, and the flags are implemented as described above.
- USEQ_RETURN_STACK_EN undefined:
  - No stack storage is built.
  - CALL behaves as SEQ.
  - RET always goes to FETCH_ADDR.
  - stack_ovf and stack_unf are tied to 0.

## Test plan
All scenarios use default parameters.
- Reset/sequence: assert rst 1 cycle → uaddr = 104, flags 0. Then SEQ with uw_j = 105, uw_cen = 0 → uaddr = 105 next cycle.
- Decode:
  - DECODE, family_number = 5, cond_pass = 1 → 40.
  - family_number = 14 → 112.
  - cond_pass = 0 → 104.
- Condition branch: uw_j = 57, uw_cen = 1, uw_csel = 2, uw_cpos = 1. With cond_in[2] = 1 → 59; with cond_in[2] = 0 → 57. With uw_cpos = 0, uw_j = 26 and the bit set → 27.
- Memory stall: uaddr = 44, uw_mem = 1, mem_ready low for 3 cycles → uaddr stays 44 with stall = 1 for 3 cycles. Raise mem_ready → uaddr = uw_j next edge, stall = 0.
- Stack (macro defined):
  - CALL at 20 with uw_j = 80 → 80.
  - CALL at 80 with uw_j = 90 → 90.
  - CALL at 90 with uw_j = 100 → 100, stack_ovf = 1.
  - RET → 81; RET → 21; RET → 104 with stack_unf = 1.
  - With the macro undefined, the same sequence gives 80, 90, 100, 104, 104, 104 and both flags 0.
- Reset mid-operation: assert rst during a stall with sp = 1 → uaddr = 104, sp = 0, stall resumes from a clean state.
